// File: rtl/tetris_board_renderer.sv
// Pixel source for the TMDS encoders: draws a 10x20 Tetris playfield with a border, three-cycle latency.
// Optional build macro GRID_LINES_EN adds per-cell grid/bevel lines on the playfield.
module tetris_board_renderer #(
  parameter int          BOARD_X0   = 240,
  parameter int          BOARD_Y0   = 80,
  parameter int          CELL_LOG2  = 4,
  parameter int          BORDER_PX  = 4,
  parameter logic [23:0] BORDER_RGB = 24'h808080
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic       vde_in,
  input  logic [1:0] cd_in,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       wr_en,
  input  logic [3:0] wr_col,
  input  logic [4:0] wr_row,
  input  logic [2:0] wr_color,
  input  logic       clr_en,
  output logic       wr_ready,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       vde_out,
  output logic [1:0] cd_out
);

  localparam int CELL = 1 << CELL_LOG2;
  localparam logic [10:0] BX_LO = 11'(BOARD_X0);
  localparam logic [10:0] BX_HI = 11'(BOARD_X0 + 10 * CELL);
  localparam logic [10:0] BY_LO = 11'(BOARD_Y0);
  localparam logic [10:0] BY_HI = 11'(BOARD_Y0 + 20 * CELL);
  localparam logic [10:0] OX_LO = 11'(BOARD_X0 - BORDER_PX);
  localparam logic [10:0] OX_HI = 11'(BOARD_X0 + 10 * CELL + BORDER_PX);
  localparam logic [10:0] OY_LO = 11'(BOARD_Y0 - BORDER_PX);
  localparam logic [10:0] OY_HI = 11'(BOARD_Y0 + 20 * CELL + BORDER_PX);

  logic [10:0] x_ext, y_ext;
  logic        board_c, outer_c, border_c;
  logic [3:0]  col_c;
  logic [4:0]  row_c;

  logic       vde_s1, board_s1, border_s1;
  logic [1:0] cd_s1;
  logic [3:0] col_s1;
  logic [4:0] row_s1;
  logic       vde_s2, border_s2;
  logic [1:0] cd_s2;
  logic [2:0] idx_s2;
  logic [23:0] rgb_c;

  logic [2:0] cells [20][10];

`ifdef GRID_LINES_EN
  localparam logic [10:0] CELL_MASK = 11'(CELL - 1);
  logic edge_c, edge_s1, edge_s2, board_s2;
`endif

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 24'h00FFFF;
      3'd2:    palette = 24'hFFFF00;
      3'd3:    palette = 24'hA000F0;
      3'd4:    palette = 24'h00FF00;
      3'd5:    palette = 24'hFF0000;
      3'd6:    palette = 24'h0000FF;
      3'd7:    palette = 24'hFF8000;
      default: palette = 24'h000000;
    endcase
  endfunction

  // No active pixel anywhere in the pipeline, so a cell update cannot tear.
  assign wr_ready = ~vde_in & ~vde_s1 & ~vde_s2;

  always_comb begin
    x_ext    = {1'b0, x_in};
    y_ext    = {1'b0, y_in};
    board_c  = (x_ext >= BX_LO) && (x_ext < BX_HI) && (y_ext >= BY_LO) && (y_ext < BY_HI);
    outer_c  = (x_ext >= OX_LO) && (x_ext < OX_HI) && (y_ext >= OY_LO) && (y_ext < OY_HI);
    border_c = outer_c & ~board_c;
    col_c    = 4'((x_ext - BX_LO) >> CELL_LOG2);
    row_c    = 5'((y_ext - BY_LO) >> CELL_LOG2);
`ifdef GRID_LINES_EN
    edge_c   = (((x_ext - BX_LO) & CELL_MASK) == 11'd0) || (((y_ext - BY_LO) & CELL_MASK) == 11'd0);
`endif
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 10; c++)
          cells[r][c] <= 3'd0;
    end else if (wr_ready && clr_en) begin
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 10; c++)
          cells[r][c] <= 3'd0;
    end else if (wr_ready && wr_en && (wr_col <= 4'd9) && (wr_row <= 5'd19)) begin
      cells[wr_row][wr_col] <= wr_color;
    end
  end

  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      vde_s1    <= 1'b0;
      cd_s1     <= 2'b00;
      board_s1  <= 1'b0;
      border_s1 <= 1'b0;
      col_s1    <= 4'd0;
      row_s1    <= 5'd0;
      vde_s2    <= 1'b0;
      cd_s2     <= 2'b00;
      border_s2 <= 1'b0;
      idx_s2    <= 3'd0;
      vde_out   <= 1'b0;
      cd_out    <= 2'b00;
      r_out     <= 8'd0;
      g_out     <= 8'd0;
      b_out     <= 8'd0;
    end else begin
      vde_s1    <= vde_in;
      cd_s1     <= cd_in;
      board_s1  <= board_c;
      border_s1 <= border_c;
      col_s1    <= col_c;
      row_s1    <= row_c;
      vde_s2    <= vde_s1;
      cd_s2     <= cd_s1;
      border_s2 <= border_s1;
      idx_s2    <= board_s1 ? cells[row_s1][col_s1] : 3'd0;
      vde_out   <= vde_s2;
      cd_out    <= cd_s2;
      {r_out, g_out, b_out} <= rgb_c;
    end
  end

`ifdef GRID_LINES_EN
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      edge_s1  <= 1'b0;
      edge_s2  <= 1'b0;
      board_s2 <= 1'b0;
    end else begin
      edge_s1  <= edge_c;
      edge_s2  <= edge_s1;
      board_s2 <= board_s1;
    end
  end
`endif

  // Border and board regions never overlap; blanking overrides everything.
  always_comb begin
    rgb_c = palette(idx_s2);
`ifdef GRID_LINES_EN
    if (board_s2 && edge_s2)
      rgb_c = (idx_s2 == 3'd0) ? 24'h303030 : ((rgb_c >> 1) & 24'h7F7F7F);
`endif
    if (border_s2)
      rgb_c = BORDER_RGB;
    if (!vde_s2)
      rgb_c = 24'h000000;
  end

endmodule

// File: doc/tetris_board_renderer.md
Name: tetris_board_renderer

Overview:
- Pixel-source stage directly upstream of the three TMDS encoders.
- Consumes the timing generator's video-enable, control-data and pixel coordinates, and produces per-pixel 8-bit R/G/B.
- Holds a 10x20 Tetris playfield of 3-bit colour indices, written by game logic, and draws it with a border.
- Re-times VDE and CD so they stay aligned with the RGB it outputs.

Parameters:
- BOARD_X0, 240, x pixel of the left edge of playfield column 0 (must be >= BORDER_PX).
- BOARD_Y0, 80, y pixel of the top edge of playfield row 0 (must be >= BORDER_PX).
- CELL_LOG2, 4, log2 of the cell size in pixels; cells are square, 16x16 at the default.
- BORDER_PX, 4, border thickness in pixels around the playfield.
- BORDER_RGB, 24'h808080, border colour, packed {R,G,B}.

Ports:
- pixclk, input, 1, pixel clock; the only clock.
- rst, input, 1, asynchronous active-high reset.
- vde_in, input, 1, video data enable from the timing generator.
- cd_in, input, 2, control data {vsync,hsync} from the timing generator.
- x_in, input, 10, current pixel column; valid when vde_in=1.
- y_in, input, 10, current pixel row; valid when vde_in=1.
- wr_en, input, 1, cell write request.
- wr_col, input, 4, target column, 0..9.
- wr_row, input, 5, target row, 0..19 (0 = top).
- wr_color, input, 3, colour index to store.
- clr_en, input, 1, clear-whole-board request.
- wr_ready, output, 1, high when writes/clears are accepted.
- r_out, output, 8, red to the encoder.
- g_out, output, 8, green to the encoder.
- b_out, output, 8, blue to the encoder.
- vde_out, output, 1, vde_in delayed 3 cycles.
- cd_out, output, 2, cd_in delayed 3 cycles.

Behaviour:
- Reset (async, rst=1):
  - All 200 cells = 0.
  - All pipeline registers = 0, so r_out/g_out/b_out/vde_out/cd_out = 0.
- Latency: fixed 3 pixclk from inputs to outputs; vde_out/cd_out are pure 3-stage delays of the inputs.
- Stage 1, registering inputs:
  - Register vde, cd, region and cell coordinates.
  - in_board when BOARD_X0 <= x < BOARD_X0+10*2^CELL_LOG2 and BOARD_Y0 <= y < BOARD_Y0+20*2^CELL_LOG2.
  - in_border when the pixel is inside the board rectangle grown by BORDER_PX on every side but not in_board.
  - col = (x-BOARD_X0)>>CELL_LOG2, row = (y-BOARD_Y0)>>CELL_LOG2. Subtraction is 11-bit; col/row are meaningful only when in_board.
- Stage 2: registered read of cell[row][col] into a colour index; forced to 0 when not in_board.
- Stage 3, registered palette lookup:
  - Index 0 = 000000, 1 = 00FFFF, 2 = FFFF00, 3 = A000F0, 4 = 00FF00, 5 = FF0000, 6 = 0000FF, 7 = FF8000.
  - in_border selects BORDER_RGB.
  - A delayed vde of 0 forces RGB = 0.
- Write handshake:
  - wr_ready = ~vde_in & ~vde_s1 & ~vde_s2, i.e. high only when no active pixel is in the pipeline. Writes therefore occur only in blanking and cannot tear.
  - A write commits on the rising edge where wr_en & wr_ready; the new value is visible to the first active pixel afterwards.
  - wr_en while wr_ready=0 is dropped; the requester holds wr_en until it sees wr_ready.
  - wr_col > 9 or wr_row > 19 with wr_ready=1: handshake completes, no cell changes.
- Clear:
  - clr_en & wr_ready zeroes all cells in one cycle.
  - If clr_en and wr_en are both high on the same accepted edge, the clear wins and the write is discarded.
- Reset mid-frame: outputs go to 0 immediately. After rst falls, output timing resynchronises 3 cycles after the inputs; the board stays cleared.
- Boundary columns/rows 0, 9, 19 and the last pixel of each cell map exactly; the pixel at x = BOARD_X0+160 is border, not board.

Optional Feature:
- Macro GRID_LINES_EN.
- When defined: inside in_board, any pixel whose in-cell x or y offset equals 0 outputs 303030 if the cell index is 0, otherwise the palette colour with each channel shifted right by 1 (bevel). Latency is unchanged.
- When undefined: cells are solid palette colour and the offset logic is not built.

Test Plan:
- Reset, then drive a full 640x480 frame with an empty board. Required:
  - 0 cycles: RGB = 808080 exactly on the border rectangle x 236..403, y 76..403.
  - 0 cycles: 000000 elsewhere.
  - vde_out/cd_out equal the inputs delayed 3 cycles.
- During vblank, write col=0,row=0,color=5 and col=9,row=19,color=2.
  - Next frame pixel (240,80) = FF0000, (255,95) = FF0000, (256,80) = 000000.
  - (399,399) = FFFF00, (400,399) = 808080.
- Assert wr_en with vde_in=1: wr_ready=0 and the write is dropped. Hold wr_en until vde falls plus 2 cycles: wr_ready rises and the write commits once.
- wr_col=10 or wr_row=20 with wr_ready=1: the handshake completes and every cell is unchanged on the next frame readout.
- Fill 3 cells, then pulse clr_en together with wr_en (col 4, row 4, colour 7): the whole board reads 000000, including (304,144).
- Assert rst mid-line: all outputs 0 within the same cycle, board cleared. After release, RGB follows the inputs with 3-cycle latency.
